sprite_reg_shadow: RTL
======================

Name: sprite_reg_shadow

Overview:
- Bus-side register bank that sits directly upstream of the VGA sprite renderer.
- Captures Avalon-MM writes for sprite coordinates and score digits into a shadow bank.
- Copies the shadow bank into an active bank once per frame, on the falling edge of VGA_VS, so the renderer never sees a half-updated frame (no tearing).
- Adds control, frame counter and readback registers.

Parameters:
- COORD_W, 8, width of each sprite coordinate register
- NUM_COORD, 10, number of coordinate registers (addresses 0..NUM_COORD-1)

Ports:
- clk  in  1  system clock, same domain as the renderer and its counters
- reset  in  1  asynchronous, active-high
- chipselect  in  1  Avalon chip select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  9  register word address
- writedata  in  32  write data
- readdata  out  32  registered read data
- VGA_VS  in  1  vertical sync from the counters, active-low
- coord_out  out  NUM_COORD*COORD_W  active coordinates; reg i at bits [i*8+7:i*8]; order is dino x/y, jump x/y, duck x/y, s_cac x/y, godzilla x/y
- score_digits  out  12  active BCD score; [3:0] ones, [7:4] tens, [11:8] hundreds
- commit_pulse  out  1  high for one cycle when the active bank loads
- irq  out  1  frame interrupt (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-high, and applies to all state.
  - Shadow and active coordinates reset to 100,100,200,150,44,200,244,100,100,4 (renderer defaults truncated to 8 bits).
  - Score resets to 000. ctrl=0, frame_count=0, vs_q=1.
  - readdata=0, commit_pulse=0, irq=0.
  - Reset mid-frame drops pending shadow writes.
- Write decode (chipselect && write, one register per cycle):
  - addr 0..9: shadow[addr] <= writedata[7:0].
  - addr 10: shadow score <= writedata[11:0]. Any nibble >9 saturates to 9.
  - addr 11: ctrl <= writedata[1:0]. bit0 IMM (immediate mode), bit1 FREEZE.
  - addr 12: software commit request (data ignored).
  - addr 13: irq clear (see Optional Feature).
  - Other addresses: ignored.
- Edge detect:
  - vs_q <= VGA_VS every cycle.
  - vs_fall = vs_q & ~VGA_VS, one cycle per frame.
- Commit:
  - Condition: (vs_fall && !FREEZE) || software-commit write.
  - On the same clock edge, active <= shadow, using shadow contents from before any write in that cycle. A write coinciding with a commit lands in shadow only and goes out on the next commit.
  - commit_pulse is registered: high the cycle after the commit edge, for exactly one cycle.
  - Two commit sources in the same cycle count as one commit.
- IMM=1: writes to addr 0..10 update shadow and active on the same edge. vsync commits continue and are harmless.
- frame_count (16 bit):
  - Increments on every vs_fall, regardless of FREEZE.
  - Wraps 0xFFFF -> 0x0000.
- Read, one-cycle latency:
  - When chipselect && read at edge k, readdata is valid after edge k.
  - Map: addr 0..9 shadow coord (zero-extended); 10 shadow score; 11 ctrl; 13 {15'b0, irq, frame_count}; all others 0.
  - readdata holds its value when not reading.
- A simultaneous read and write to the same address returns the old value.

Optional Feature:
- Macro: SPRITE_REG_SHADOW_IRQ_EN.
- Defined:
  - irq sets on every commit and stays high until a write to addr 13.
  - If set and clear happen in the same cycle, set wins.
- Undefined:
  - irq is tied 0 and writes to addr 13 are ignored.
  - Read of addr 13 returns bit16 = 0.

Test Plan:
- Reset, VGA_VS=1 -> coord_out reg0=100, reg9=4, score_digits=0x000, readdata=0, irq=0.
- Write addr0=0x37, addr10=0x1A5, VGA_VS held high -> coord reg0 still 100; readback addr0=0x37, addr10=0x195 (A saturated to 9).
- Drive VGA_VS 1->0 -> active reg0=0x37 and score 0x195 on that edge; commit_pulse high exactly one cycle; frame_count=1.
- Write addr1=0x55 in the vs_fall cycle -> reg1 unchanged this frame, becomes 0x55 after the next vs_fall.
- Write ctrl=2 (FREEZE), then two vs_fall edges -> active unchanged, frame_count +2; write addr12 -> active loads the next cycle.
- With SPRITE_REG_SHADOW_IRQ_EN defined: commit -> irq=1; write addr13 in the same cycle as a commit -> irq stays 1; lone write addr13 -> irq=0.

Source files
------------

// File: rtl/sprite_reg_shadow_if.sv
// Avalon-MM slave bus for the sprite register shadow bank.
// Handshake: a transfer happens on any clock edge where chipselect is high together with write or read;
// there is no waitrequest, and readdata is valid in the cycle after the read edge and holds until the next read.
interface sprite_reg_shadow_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [8:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );
endinterface

// File: rtl/sprite_reg_shadow.sv
// Shadow/active register bank for the sprite renderer; the active bank loads once per frame on the falling edge of VGA_VS.
// Optional frame interrupt enabled with macro SPRITE_REG_SHADOW_IRQ_EN.
module sprite_reg_shadow #(
    parameter int COORD_W   = 8,
    parameter int NUM_COORD = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    sprite_reg_shadow_if.slave             bus,
    input  logic                           VGA_VS,
    output logic [NUM_COORD*COORD_W-1:0]   coord_out,
    output logic [11:0]                    score_digits,
    output logic                           commit_pulse,
    output logic                           irq
);

    localparam logic [8:0] ADDR_SCORE  = 9'd10;
    localparam logic [8:0] ADDR_CTRL   = 9'd11;
    localparam logic [8:0] ADDR_COMMIT = 9'd12;
    localparam logic [8:0] ADDR_IRQ    = 9'd13;

    // Renderer power-on sprite positions, truncated to the register width.
    function automatic logic [COORD_W-1:0] coord_default(input int idx);
        logic [31:0] v;
        case (idx)
            0:       v = 32'd100;
            1:       v = 32'd100;
            2:       v = 32'd200;
            3:       v = 32'd150;
            4:       v = 32'd44;
            5:       v = 32'd200;
            6:       v = 32'd244;
            7:       v = 32'd100;
            8:       v = 32'd100;
            9:       v = 32'd4;
            default: v = 32'd0;
        endcase
        return v[COORD_W-1:0];
    endfunction

    function automatic logic [11:0] bcd_saturate(input logic [11:0] raw);
        logic [11:0] s;
        for (int n = 0; n < 3; n++) begin
            s[n*4 +: 4] = (raw[n*4 +: 4] > 4'd9) ? 4'd9 : raw[n*4 +: 4];
        end
        return s;
    endfunction

    logic [COORD_W-1:0] shadow_coord [NUM_COORD];
    logic [COORD_W-1:0] active_coord [NUM_COORD];
    logic [11:0]        shadow_score;
    logic [11:0]        active_score;
    logic [1:0]         ctrl;
    logic [15:0]        frame_count;
    logic               vs_q;

    logic        wr_en;
    logic        rd_en;
    logic        vs_fall;
    logic        commit;
    logic        imm;
    logic        freeze;
    logic        score_wr;
    logic [11:0] score_wdata;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign wr_en       = bus.chipselect && bus.write;
    assign rd_en       = bus.chipselect && bus.read;
    assign imm         = ctrl[0];
    assign freeze      = ctrl[1];
    assign vs_fall     = vs_q && !VGA_VS;
    assign commit      = (vs_fall && !freeze) || (wr_en && bus.address == ADDR_COMMIT);
    assign score_wr    = wr_en && bus.address == ADDR_SCORE;
    assign score_wdata = bcd_saturate(bus.writedata[11:0]);
    assign unused_bits = ^bus.writedata[31:12];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COORD; i++) shadow_coord[i] <= coord_default(i);
            shadow_score <= 12'h000;
        end else begin
            for (int i = 0; i < NUM_COORD; i++) begin
                if (wr_en && bus.address == 9'(i)) shadow_coord[i] <= bus.writedata[COORD_W-1:0];
            end
            if (score_wr) shadow_score <= score_wdata;
        end
    end

    // Commit copies the pre-write shadow; an immediate-mode write then overrides its own register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COORD; i++) active_coord[i] <= coord_default(i);
            active_score <= 12'h000;
        end else begin
            for (int i = 0; i < NUM_COORD; i++) begin
                if (commit) active_coord[i] <= shadow_coord[i];
                if (imm && wr_en && bus.address == 9'(i)) active_coord[i] <= bus.writedata[COORD_W-1:0];
            end
            if (commit) active_score <= shadow_score;
            if (imm && score_wr) active_score <= score_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl         <= 2'b00;
            frame_count  <= 16'h0000;
            vs_q         <= 1'b1;
            commit_pulse <= 1'b0;
        end else begin
            vs_q         <= VGA_VS;
            commit_pulse <= commit;
            if (wr_en && bus.address == ADDR_CTRL) ctrl <= bus.writedata[1:0];
            if (vs_fall) frame_count <= frame_count + 16'd1;
        end
    end

`ifdef SPRITE_REG_SHADOW_IRQ_EN
    logic irq_clr;
    assign irq_clr = wr_en && bus.address == ADDR_IRQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        irq <= 1'b0;
        else if (commit)  irq <= 1'b1;
        else if (irq_clr) irq <= 1'b0;
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_data = 32'h0;
        for (int i = 0; i < NUM_COORD; i++) begin
            if (bus.address == 9'(i)) rd_data = 32'(shadow_coord[i]);
        end
        case (bus.address)
            ADDR_SCORE: rd_data = {20'h0, shadow_score};
            ADDR_CTRL:  rd_data = {30'h0, ctrl};
            ADDR_IRQ:   rd_data = {15'h0, irq, frame_count};
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      bus.readdata <= 32'h0;
        else if (rd_en) bus.readdata <= rd_data;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_COORD; g++) begin : g_coord_out
            assign coord_out[g*COORD_W +: COORD_W] = active_coord[g];
        end
    endgenerate

    assign score_digits = active_score;

endmodule
